// File: rtl/io_pkg.sv
// Shared types and constants for the input port.
// Exports in_state_t, BUS_W, DEBOUNCE_DEFAULT.
package io_pkg;

  localparam int BUS_W = 8;

  // 10 ms at 27 MHz
  localparam int DEBOUNCE_DEFAULT = 270000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } in_state_t;

endpackage

// File: rtl/debouncer.sv
// Key synchronizer + debouncer, emits a one-cycle press pulse.
// Ports: clk, rst (async low), key_n (raw), press (1->0 event).
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic             k1;
  logic             k2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Level flips on the edge where the counter has
  // already seen DEBOUNCE_CYCLES-1 mismatching samples.
  assign flip  = (k2 != level) &&
                 (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press = flip && level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k1    <= 1'b1;
      k2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      k1 <= key_n;
      k2 <= k1;
      if (k2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_module.sv
// Switch input register with debounced enter key and bus drive.
// Ports: clk, rst, bus, IO, sw, key_n, data_valid, overrun, led.
module input_module
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [BUS_W-1:0] bus,
  input  logic             IO,
  input  logic [BUS_W-1:0] sw,
  input  logic             key_n,
  output logic             data_valid,
  output logic             overrun,
  output logic [BUS_W-1:0] led
);

  logic [BUS_W-1:0] sw1;
  logic [BUS_W-1:0] sw_s;
  logic [BUS_W-1:0] data_reg;
  logic             press;
  in_state_t        state;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_deb (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .press(press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw1  <= '0;
      sw_s <= '0;
    end else begin
      sw1  <= sw;
      sw_s <= sw1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      data_reg <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (press) begin
            data_reg <= sw_s;
            state    <= FULL;
          end
          if (IO) overrun <= 1'b0;
        end
        FULL: begin
          if (press) begin
            data_reg <= sw_s;
            // A same-cycle read consumed the old byte.
            overrun  <= !IO;
          end else if (IO) begin
            state   <= EMPTY;
            overrun <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign data_valid = (state == FULL);
  assign led        = data_reg;

  // Never drive the shared bus while held in reset.
  assign bus = (IO && rst) ? data_reg : {BUS_W{1'bz}};

endmodule

// File: tb/tb_input_module.sv
// Randomized + directed bench for input_module against a
// behavioural model of key debounce and the input register.
module tb_input_module;
  import io_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io = 1'b0;
  logic       key_n = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       tb_en = 1'b1;
  logic [7:0] tb_val = 8'h00;
  wire  [7:0] bus;
  logic       dv;
  logic       ov;
  logic [7:0] led;

  assign bus = tb_en ? tb_val : 8'bz;

  input_module #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .IO(io),
    .sw(sw),
    .key_n(key_n),
    .data_valid(dv),
    .overrun(ov),
    .led(led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: raw samples delayed two edges, sync samples since
  // last flip, and the architectural register state
  bit         kq[$];
  logic [7:0] swq[$];
  bit         hist[$];
  bit         m_lvl;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovr;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kq      = '{1'b1, 1'b1};
    swq     = '{8'h00, 8'h00};
    hist    = {};
    m_lvl   = 1'b1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge();
    bit         ks;
    bit         pr;
    bit         all_diff;
    logic [7:0] sv;
    if (!rst) begin
      model_reset();
      return;
    end
    ks = kq.pop_front();
    kq.push_back(key_n);
    sv = swq.pop_front();
    swq.push_back(sw);
    pr = 1'b0;
    hist.push_back(ks);
    if (hist.size() > D) void'(hist.pop_front());
    all_diff = (hist.size() == D);
    foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 1'b0;
    if (all_diff) begin
      pr    = m_lvl;
      m_lvl = !m_lvl;
      hist  = {};
    end
    if (pr) begin
      if (io) m_ovr = 1'b0;
      else if (m_valid) m_ovr = 1'b1;
      m_data  = sv;
      m_valid = 1'b1;
    end else if (io) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic step(bit i, bit k, logic [7:0] s);
    io     = i;
    key_n  = k;
    sw     = s;
    tb_en  = !(i && rst);
    tb_val = 8'($urandom);
    #1;
    if (tb_en) chk("bus_release", bus, tb_val);
    else chk("bus_read", bus, m_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("data_valid", {7'b0, dv}, {7'b0, m_valid});
    chk("overrun", {7'b0, ov}, {7'b0, m_ovr});
    chk("led", led, m_data);
  endtask

  task automatic press(logic [7:0] s, int lo, int hi);
    for (int n = 0; n < lo; n++) step(1'b0, 1'b0, s);
    for (int n = 0; n < hi; n++) step(1'b0, 1'b1, s);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // reset with IO held high
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 8'hFF);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 8'h00);
    chk("reset_dv", {7'b0, dv}, 8'h00);
    chk("reset_led", led, 8'h00);

    // clean press: valid exactly 6 edges after the fall
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 1'b0, 8'hA5);
      chk("clean_latency", {7'b0, dv}, {7'b0, n >= 6});
    end
    press(8'hA5, 0, 8);
    chk("clean_led", led, 8'hA5);
    step(1'b1, 1'b1, 8'hA5);
    chk("clean_read_dv", {7'b0, dv}, 8'h00);

    // bounce never latches
    press(8'h5A, 3, 1);
    press(8'h5A, 3, 8);
    chk("bounce_dv", {7'b0, dv}, 8'h00);
    press(8'h5A, 8, 8);
    chk("bounce_latch_dv", {7'b0, dv}, 8'h01);
    chk("bounce_latch_led", led, 8'h5A);
    step(1'b1, 1'b1, 8'h00);

    // overrun then read
    press(8'h11, 8, 8);
    press(8'h22, 8, 8);
    chk("ovr_led", led, 8'h22);
    chk("ovr_flag", {7'b0, ov}, 8'h01);
    step(1'b1, 1'b1, 8'h22);
    chk("ovr_clr_dv", {7'b0, dv}, 8'h00);
    chk("ovr_clr_ov", {7'b0, ov}, 8'h00);

    // press pulse coincident with a read
    press(8'h33, 8, 8);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 8'h44);
    io = 1'b1;
    tb_en = 1'b0;
    #1;
    chk("simul_bus_old", bus, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    chk("simul_led", led, 8'h44);
    chk("simul_dv", {7'b0, dv}, 8'h01);
    chk("simul_ov", {7'b0, ov}, 8'h00);
    press(8'h44, 2, 8);
    step(1'b1, 1'b1, 8'h00);

    // reset mid-debounce
    press(8'h77, 2, 0);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h77);
    rst = 1'b1;
    press(8'h77, 0, 8);
    chk("mid_rst_dv", {7'b0, dv}, 8'h00);
    press(8'h66, 8, 8);
    chk("post_rst_led", led, 8'h66);

    // randomized presses, bounces and reads
    for (int r = 0; r < 40; r++) begin
      logic [7:0] s;
      int lo;
      int hi;
      s  = 8'($urandom);
      lo = $urandom_range(1, 10);
      hi = $urandom_range(1, 10);
      for (int n = 0; n < lo; n++)
        step($urandom_range(0, 5) == 0, 1'b0, s);
      for (int n = 0; n < hi; n++)
        step($urandom_range(0, 5) == 0, 1'b1, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_module.md
# input_module

Input port of the 8-bit computer: the counterpart of the output register/display path. It samples the board's eight data switches, debounces an active-low "enter" pushbutton, and latches the switch value on each confirmed press. It presents the latched byte on the shared tri-state `bus` when the control word asserts `IO`, and it exposes a valid/overrun status so programs can poll for fresh input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable `clk` cycles required before a key level is accepted (10 ms at 27 MHz). Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clk` input 1: system clock, single clock domain. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `bus` inout 8: shared system bus. Driven only while `IO`=1, otherwise high-Z.
- `IO` input 1: control signal, "input register out". Drive the latched byte onto `bus`.
- `sw` input 8: raw asynchronous data switches.
- `key_n` input 1: raw asynchronous pushbutton, 0 = pressed.
- `data_valid` output 1: a latched byte has not been read yet.
- `overrun` output 1: sticky flag. A press overwrote an unread byte.
- `led` output 8: mirror of the latched byte for board LEDs.

## Operation
- Synchronizer: `sw` and `key_n` each pass through 2 flops. Only the synchronized versions are used downstream.
- Debounce on synchronized `key_n`:
  - The counter reloads to 0 whenever the synchronized level equals the current debounced level.
  - Otherwise the counter increments.
  - When it reaches `DEBOUNCE_CYCLES`-1, the debounced level flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never flips the level.
- Press event: a single-cycle pulse when the debounced level goes 1→0. Release produces no event.
- The FSM has states EMPTY and FULL.
- EMPTY:
  - On a press, latch the synchronized `sw` into `data_reg` and go to FULL.
  - `IO` reads in EMPTY return the stale `data_reg`, leave the state unchanged, and clear nothing.
- FULL:
  - On `IO`=1 with no press, go to EMPTY.
  - On a press with `IO`=0, re-latch `sw`, set `overrun`, and stay in FULL.
  - On a press and `IO`=1 in the same cycle, the bus shows the old byte during that cycle. The new byte is latched at the edge, the state stays FULL, and `overrun` is not set (the old byte was consumed).
- `overrun` clears at any edge where `IO`=1 and no press-with-`IO`=0 overrun condition exists. A read acknowledges both flags.
- Outputs:
  - `data_valid` = (state == FULL).
  - `led` = `data_reg`.
  - `bus` = `IO` ? `data_reg` : 8'bz.
- `IO` held for several cycles counts as one read per cycle. Only the first cycle can change state, because subsequent cycles find EMPTY.
- Reset:
  - Reset values: `data_reg`=8'h00, state EMPTY, `overrun`=0, debounced level=1 (released), counter=0, synchronizer flops=1 for key and 0 for switches.
  - `bus` is high-Z during reset regardless of `IO`.
  - Reset mid-debounce discards the partial count.

## Timing
- `bus` drive is combinational from `IO`: valid in the same cycle `IO` rises, with no register stage, so the consuming register captures at that cycle's edge.
- Key-to-latch latency: `key_n` held low from edge N, sampled stable, gives the press pulse at edge N+2+`DEBOUNCE_CYCLES`. `data_valid` is high after that edge.
- The latched switch value is the synchronized `sw` at the press-pulse edge, i.e. raw `sw` from 2 cycles earlier.
- Read-to-clear: `data_valid` falls after the edge at which `IO`=1 is sampled.

## Structure
- Package `io_pkg`:
  - State enum `in_state_t` {EMPTY, FULL}.
  - Bus width constant `BUS_W`=8.
  - Default debounce constant.
- Sub-module `debouncer`: synchronizer, counter, and press pulse, parameterized by `DEBOUNCE_CYCLES`. `input_module` instantiates it once for `key_n`. The `sw` synchronizer stays in the top module.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- Reset: `rst`=0 with `IO`=1 → `bus`=Z, `data_valid`=0, `overrun`=0, `led`=00. Releasing reset changes nothing.
- Clean press: `sw`=8'hA5, `key_n` low 10 cycles → `data_valid` rises exactly 6 edges after the fall and `led`=A5. `IO` pulse for 1 cycle → `bus`=A5 that cycle, then `data_valid`=0.
- Bounce: `key_n` toggles low for 3 cycles, high for 1, low for 3, then high → no latch, `data_valid` stays 0. A subsequent 8-cycle low latches once.
- Overrun: press with `sw`=8'h11, then press with `sw`=8'h22 and no read → `led`=22, `overrun`=1. `IO` read → `bus`=22, both flags clear.
- Simultaneous: in FULL holding 8'h33, press pulse with `sw`=8'h44 coincident with `IO`=1 → `bus`=33 that cycle, then `led`=44, `data_valid`=1, `overrun`=0.
- Reset mid-debounce: `rst` asserted 2 cycles into a press → counter cleared and no latch. A press after release latches normally.
